complex_alu_ctrl: RTL and testbench
===================================

# complex_alu_ctrl

Sequencing controller for the combinational complex ALU (multiply, divide, syscall) in the execute stage. The controller accepts one complex op at a time from the issue queue and latches its operands and opcode to drive the ALU. It waits an opcode-class-dependent latency, then holds the captured result, flags and tag in an output buffer until writeback accepts them. It gives the scheduler a valid/ready issue port, a valid/ready writeback port and flush support.

## Interface
- MUL_LAT, 3, cycles for MULT_L/MULT_H/MULTU_L/MULTU_H (≥1)
- DIV_LAT, 16, cycles for DIV_L/DIV_H/DIVU_L/DIVU_H (≥1)
- TAG_W, 7, width of destination tag carried with the op
- clk  in  1  clock; only clock
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  squash any in-flight op
- issue_valid_i  in  1  op presented
- issue_ready_o  out  1  controller can accept op this cycle
- issue_opcode_i  in  `SIZE_OPCODE_I  opcode
- issue_data1_i, issue_data2_i  in  `SIZE_DATA  operands
- issue_immd_i  in  `SIZE_IMMEDIATE  immediate
- issue_tag_i  in  TAG_W  destination tag
- alu_data1_o, alu_data2_o  out  `SIZE_DATA  latched operands to ALU
- alu_immd_o  out  `SIZE_IMMEDIATE  latched immediate
- alu_opcode_o  out  `SIZE_OPCODE_I  latched opcode
- alu_result_i  in  `SIZE_DATA  ALU result
- alu_flags_i  in  `EXECUTION_FLAGS  ALU flags
- wb_valid_o  out  1  result buffer valid
- wb_ready_i  in  1  writeback accepts
- wb_result_o  out  `SIZE_DATA; wb_flags_o  out  `EXECUTION_FLAGS; wb_tag_o  out  TAG_W
- busy_o  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, BUSY, DONE.
- Issue handshake is issue_valid_i && issue_ready_o.
- issue_ready_o = !flush_i && (IDLE || (DONE && wb_ready_i)). This is a combinational path from wb_ready_i and is permitted.
- On handshake: latch opcode, operands, immediate and tag into the operand register. Load cnt with LAT−1, where LAT is selected as follows:
  - MULT*: MUL_LAT.
  - DIV*: DIV_LAT.
  - SYSCALL and all other opcodes: 1.
  - State goes to BUSY.
- BUSY, cnt≠0: decrement cnt.
- BUSY, cnt==0: capture alu_result_i, alu_flags_i and the latched tag into the output buffer. State goes to DONE.
- DONE: wb_valid_o=1; buffer contents stay stable while wb_ready_i=0.
  - wb_ready_i=1 with a handshake: go to BUSY with the new op.
  - wb_ready_i=1 without a handshake: go to IDLE.
- ALU outputs are always driven from the operand register. The register retains the last op in IDLE/DONE.
- Result and flags are passed through unmodified, including divide-by-zero and unknown opcodes.
- flush_i (priority over everything except reset):
  - Next state is IDLE and wb_valid_o drops next cycle.
  - No handshake occurs in the flush cycle.
  - Any BUSY or DONE op is discarded. A DONE op that completes a wb handshake in the same cycle as the flush is still delivered.
- reset: all outputs and registers go to 0 and state goes to IDLE, including mid-BUSY or mid-DONE.

## Timing
- Handshake in cycle T. wb_valid_o first high in cycle T+LAT+1. The ALU is sampled at the end of cycle T+LAT.
- Best-case throughput is one op per LAT+1 cycles (back-to-back via DONE→BUSY).
- While BUSY, issue_ready_o=0. Holding issue_valid_i has no effect.
- Reset values: issue_ready_o=1 after the reset cycle; all other outputs 0.
- cnt width is $clog2(max(MUL_LAT,DIV_LAT)); no wrap: cnt stops at 0.

## Structure
- Shared package holds:
  - the opcode macros (`MULT_L … `SYSCALL);
  - the opcode-class enum (CLS_MUL, CLS_DIV, CLS_ONE);
  - the FSM state typedef.
- Sub-module complex_lat_decode: combinational map from opcode to LAT−1 for counter load, parameterised by MUL_LAT/DIV_LAT.
- The ALU is external; the controller only drives and samples it.

## Test plan
- Reset: assert reset 2 cycles mid-BUSY → next cycle busy_o=0, wb_valid_o=0, issue_ready_o=1, all data outputs 0.
- MULT_L, data1=7, data2=−3 (0xFFFFFFFD), tag=5, MUL_LAT=3, handshake at T:
  - wb_valid_o rises at T+4 with wb_result_o=−21 and wb_tag_o=5.
  - issue_ready_o=0 during T+1..T+3.
- DIVU_L 100/7 with DIV_LAT=16 → wb_result_o=14 at T+17. Then, with wb_ready_i=0 for 5 cycles, result, flags and tag hold stable and wb_valid_o stays 1.
- Back-to-back: in the DONE cycle, wb_ready_i=1 with issue_valid_i (MULTU_H 0xFFFFFFFF×2) → first result accepted, second op's wb_valid_o rises 4 cycles later with result 1.
- flush_i in the 2nd BUSY cycle of a DIV → next cycle IDLE, wb_valid_o never rises for that op. A new SYSCALL issued afterwards returns at T+2 with flags {0,0,0,1,1,0}.
- flush_i in the same cycle as issue_valid_i → no handshake; the op is not executed.

Source files
------------

// File: rtl/complex_alu_ctrl_pkg.sv
// complex_alu_ctrl_pkg: shared opcode encodings, widths, op classes and FSM state for the complex ALU controller
`ifndef COMPLEX_ALU_CTRL_DEFS
`define COMPLEX_ALU_CTRL_DEFS
`define SIZE_OPCODE_I 8
`define SIZE_DATA 32
`define SIZE_IMMEDIATE 16
`define EXECUTION_FLAGS 6
`define MULT_L 8'h1c
`define MULT_H 8'h1d
`define MULTU_L 8'h1e
`define MULTU_H 8'h1f
`define DIV_L 8'h20
`define DIV_H 8'h21
`define DIVU_L 8'h22
`define DIVU_H 8'h23
`define SYSCALL 8'h24
`endif

package complex_alu_ctrl_pkg;
    localparam int OPC_W = `SIZE_OPCODE_I;
    localparam int DATA_W = `SIZE_DATA;
    localparam int IMM_W = `SIZE_IMMEDIATE;
    localparam int FLG_W = `EXECUTION_FLAGS;
    localparam logic [OPC_W-1:0] OP_MULT_L = `MULT_L;
    localparam logic [OPC_W-1:0] OP_MULT_H = `MULT_H;
    localparam logic [OPC_W-1:0] OP_MULTU_L = `MULTU_L;
    localparam logic [OPC_W-1:0] OP_MULTU_H = `MULTU_H;
    localparam logic [OPC_W-1:0] OP_DIV_L = `DIV_L;
    localparam logic [OPC_W-1:0] OP_DIV_H = `DIV_H;
    localparam logic [OPC_W-1:0] OP_DIVU_L = `DIVU_L;
    localparam logic [OPC_W-1:0] OP_DIVU_H = `DIVU_H;
    localparam logic [OPC_W-1:0] OP_SYSCALL = `SYSCALL;
    typedef enum logic [1:0] {CLS_MUL, CLS_DIV, CLS_ONE} op_cls_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    function automatic op_cls_t op_class(input logic [OPC_W-1:0] op);
        return (op inside {OP_MULT_L, OP_MULT_H, OP_MULTU_L, OP_MULTU_H}) ? CLS_MUL :
               (op inside {OP_DIV_L, OP_DIV_H, OP_DIVU_L, OP_DIVU_H}) ? CLS_DIV : CLS_ONE;
    endfunction
endpackage

// File: rtl/complex_lat_decode.sv
// complex_lat_decode: maps an opcode to its latency minus one for the controller's countdown
// ports: opcode in, lat_m1 out (MUL_LAT-1 / DIV_LAT-1 / 0 for single-cycle ops)
module complex_lat_decode
    import complex_alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16,
    parameter int CNT_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output logic [CNT_W-1:0] lat_m1
);
    op_cls_t cls;
    always_comb begin
        cls = op_class(opcode);
        lat_m1 = cls == CLS_MUL ? CNT_W'(MUL_LAT - 1) : cls == CLS_DIV ? CNT_W'(DIV_LAT - 1) : '0;
    end
endmodule

// File: rtl/complex_alu_ctrl.sv
// complex_alu_ctrl: sequences one multi-cycle op at a time through the external complex ALU
// ports: issue_* valid/ready op input; alu_* latched operands out, result/flags in;
//        wb_* valid/ready result buffer; flush_i squashes in-flight op; busy_o = not idle
module complex_alu_ctrl
    import complex_alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16,
    parameter int TAG_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [OPC_W-1:0]  issue_opcode_i,
    input  logic [DATA_W-1:0] issue_data1_i,
    input  logic [DATA_W-1:0] issue_data2_i,
    input  logic [IMM_W-1:0]  issue_immd_i,
    input  logic [TAG_W-1:0]  issue_tag_i,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [IMM_W-1:0]  alu_immd_o,
    output logic [OPC_W-1:0]  alu_opcode_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [FLG_W-1:0]  alu_flags_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [DATA_W-1:0] wb_result_o,
    output logic [FLG_W-1:0]  wb_flags_o,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic              busy_o
);
    localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
    localparam int CNT_W = MAX_LAT > 1 ? $clog2(MAX_LAT) : 1;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, lat_m1;
    logic [TAG_W-1:0] tag_q;
    logic hs, last;
    complex_lat_decode #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_lat (
        .opcode (issue_opcode_i),
        .lat_m1 (lat_m1)
    );
    always_comb begin
        issue_ready_o = !flush_i && (state == IDLE || (state == DONE && wb_ready_i));
        hs = issue_valid_i && issue_ready_o;
        last = state == BUSY && cnt == '0;
        state_n = flush_i ? IDLE : hs ? BUSY : last ? DONE : (state == DONE && wb_ready_i) ? IDLE : state;
        wb_valid_o = state == DONE;
        busy_o = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            tag_q <= '0;
            alu_opcode_o <= '0;
            alu_data1_o <= '0;
            alu_data2_o <= '0;
            alu_immd_o <= '0;
            wb_result_o <= '0;
            wb_flags_o <= '0;
            wb_tag_o <= '0;
        end else begin
            state <= state_n;
            if (hs) begin
                cnt <= lat_m1;
                tag_q <= issue_tag_i;
                alu_opcode_o <= issue_opcode_i;
                alu_data1_o <= issue_data1_i;
                alu_data2_o <= issue_data2_i;
                alu_immd_o <= issue_immd_i;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            // a squashed op must not overwrite the buffer of a previously delivered result
            if (last && !flush_i) begin
                wb_result_o <= alu_result_i;
                wb_flags_o <= alu_flags_i;
                wb_tag_o <= tag_q;
            end
        end
    end
endmodule

// File: tb/tb_complex_alu_ctrl.sv
// tb_complex_alu_ctrl: directed and randomized checks of complex_alu_ctrl against a cycle-count reference model
module tb_complex_alu_ctrl;
    import complex_alu_ctrl_pkg::*;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 16;
    localparam int TAG_W = 7;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset, flush_i, issue_valid_i, wb_ready_i;
    logic issue_ready_o, wb_valid_o, busy_o;
    logic [OPC_W-1:0] issue_opcode_i, alu_opcode_o;
    logic [DATA_W-1:0] issue_data1_i, issue_data2_i, alu_data1_o, alu_data2_o, alu_result_i, wb_result_o;
    logic [IMM_W-1:0] issue_immd_i, alu_immd_o;
    logic [FLG_W-1:0] alu_flags_i, wb_flags_o;
    logic [TAG_W-1:0] issue_tag_i, wb_tag_o;
    int n_cmp = 0;
    int n_bad = 0;
    complex_alu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_opcode_i (issue_opcode_i),
        .issue_data1_i  (issue_data1_i),
        .issue_data2_i  (issue_data2_i),
        .issue_immd_i   (issue_immd_i),
        .issue_tag_i    (issue_tag_i),
        .alu_data1_o    (alu_data1_o),
        .alu_data2_o    (alu_data2_o),
        .alu_immd_o     (alu_immd_o),
        .alu_opcode_o   (alu_opcode_o),
        .alu_result_i   (alu_result_i),
        .alu_flags_i    (alu_flags_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_result_o    (wb_result_o),
        .wb_flags_o     (wb_flags_o),
        .wb_tag_o       (wb_tag_o),
        .busy_o         (busy_o)
    );
    function automatic logic [DATA_W-1:0] alu_res(input logic [OPC_W-1:0] op, input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b, input logic [IMM_W-1:0] imm);
        logic signed [63:0] ps;
        logic [63:0] pu;
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu = {32'b0, a} * {32'b0, b};
        case (op)
            OP_MULT_L: return ps[31:0];
            OP_MULT_H: return ps[63:32];
            OP_MULTU_L: return pu[31:0];
            OP_MULTU_H: return pu[63:32];
            OP_DIV_L: return b == 0 ? '1 : DATA_W'($signed(a) / $signed(b));
            OP_DIV_H: return b == 0 ? a : DATA_W'($signed(a) % $signed(b));
            OP_DIVU_L: return b == 0 ? '1 : a / b;
            OP_DIVU_H: return b == 0 ? a : a % b;
            default: return a + {{16{imm[15]}}, imm};
        endcase
    endfunction
    function automatic logic [FLG_W-1:0] alu_flg(input logic [OPC_W-1:0] op, input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return op == OP_SYSCALL ? 6'b000110 : {b == 0, a[31], op[3:0]};
    endfunction
    function automatic int lat_of(input logic [OPC_W-1:0] op);
        if (op inside {OP_MULT_L, OP_MULT_H, OP_MULTU_L, OP_MULTU_H}) return MUL_LAT;
        if (op inside {OP_DIV_L, OP_DIV_H, OP_DIVU_L, OP_DIVU_H}) return DIV_LAT;
        return 1;
    endfunction
    always_comb begin
        alu_result_i = alu_res(alu_opcode_o, alu_data1_o, alu_data2_o, alu_immd_o);
        alu_flags_i = alu_flg(alu_opcode_o, alu_data1_o, alu_data2_o);
    end
    // reference model: cycles left until the in-flight result appears, plus the visible buffer
    int m_left;
    bit m_valid;
    logic [DATA_W-1:0] m_res, p_res, l_d1, l_d2;
    logic [FLG_W-1:0] m_flg, p_flg;
    logic [TAG_W-1:0] m_tag, p_tag;
    logic [OPC_W-1:0] l_op;
    logic [IMM_W-1:0] l_imm;
    task automatic model_clear();
        m_left = 0;
        m_valid = 0;
        m_res = '0;
        m_flg = '0;
        m_tag = '0;
        p_res = '0;
        p_flg = '0;
        p_tag = '0;
        l_op = '0;
        l_d1 = '0;
        l_d2 = '0;
        l_imm = '0;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        bit e_busy, e_rdy, acc;
        #1;
        e_busy = m_valid || m_left > 0;
        e_rdy = !flush_i && (!e_busy || (m_valid && wb_ready_i));
        chk("issue_ready", issue_ready_o, e_rdy);
        chk("busy", busy_o, e_busy);
        chk("wb_valid", wb_valid_o, m_valid);
        chk("wb_result", wb_result_o, m_res);
        chk("wb_flags", wb_flags_o, m_flg);
        chk("wb_tag", wb_tag_o, m_tag);
        chk("alu_opcode", alu_opcode_o, l_op);
        chk("alu_data1", alu_data1_o, l_d1);
        chk("alu_data2", alu_data2_o, l_d2);
        chk("alu_immd", alu_immd_o, l_imm);
        acc = issue_valid_i && e_rdy;
        if (reset) begin
            model_clear();
        end else if (flush_i) begin
            m_valid = 0;
            m_left = 0;
        end else begin
            if (m_valid && wb_ready_i) m_valid = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1;
                    m_res = p_res;
                    m_flg = p_flg;
                    m_tag = p_tag;
                end
            end
            if (acc) begin
                m_left = lat_of(issue_opcode_i);
                p_res = alu_res(issue_opcode_i, issue_data1_i, issue_data2_i, issue_immd_i);
                p_flg = alu_flg(issue_opcode_i, issue_data1_i, issue_data2_i);
                p_tag = issue_tag_i;
                l_op = issue_opcode_i;
                l_d1 = issue_data1_i;
                l_d2 = issue_data2_i;
                l_imm = issue_immd_i;
            end
        end
        @(negedge clk);
    endtask
    task automatic issue(input logic [OPC_W-1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [TAG_W-1:0] tag);
        issue_valid_i = 1;
        issue_opcode_i = op;
        issue_data1_i = a;
        issue_data2_i = b;
        issue_immd_i = 16'h0040;
        issue_tag_i = tag;
        tick();
        issue_valid_i = 0;
    endtask
    initial begin
        logic [OPC_W-1:0] ops [10];
        ops = '{OP_MULT_L, OP_MULT_H, OP_MULTU_L, OP_MULTU_H, OP_DIV_L, OP_DIV_H, OP_DIVU_L, OP_DIVU_H,
                OP_SYSCALL, 8'h05};
        reset = 1;
        flush_i = 0;
        issue_valid_i = 0;
        wb_ready_i = 0;
        issue_opcode_i = '0;
        issue_data1_i = '0;
        issue_data2_i = '0;
        issue_immd_i = '0;
        issue_tag_i = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        chk("rst_ready", issue_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        tick();
        issue(OP_MULT_L, 32'd7, 32'hFFFFFFFD, 7'd5);
        issue_valid_i = 1;
        issue_opcode_i = OP_SYSCALL;
        repeat (3) begin
            chk("mul_ready_low", issue_ready_o, 0);
            tick();
        end
        issue_valid_i = 0;
        chk("mul_valid", wb_valid_o, 1);
        chk("mul_result", wb_result_o, 32'hFFFFFFEB);
        chk("mul_tag", wb_tag_o, 7'd5);
        wb_ready_i = 1;
        tick();
        wb_ready_i = 0;
        issue(OP_DIVU_L, 32'd100, 32'd7, 7'd9);
        repeat (16) tick();
        repeat (5) begin
            chk("div_valid", wb_valid_o, 1);
            chk("div_result", wb_result_o, 32'd14);
            chk("div_flags", wb_flags_o, 6'b000010);
            chk("div_tag", wb_tag_o, 7'd9);
            tick();
        end
        wb_ready_i = 1;
        issue(OP_MULTU_H, 32'hFFFFFFFF, 32'd2, 7'd3);
        wb_ready_i = 0;
        repeat (3) tick();
        chk("b2b_valid", wb_valid_o, 1);
        chk("b2b_result", wb_result_o, 32'd1);
        chk("b2b_tag", wb_tag_o, 7'd3);
        wb_ready_i = 1;
        tick();
        wb_ready_i = 0;
        issue(OP_DIV_L, 32'd50, 32'd5, 7'd11);
        tick();
        flush_i = 1;
        tick();
        flush_i = 0;
        chk("flush_idle", busy_o, 0);
        repeat (20) begin
            chk("flush_no_valid", wb_valid_o, 0);
            tick();
        end
        issue(OP_SYSCALL, 32'd0, 32'd0, 7'd1);
        tick();
        chk("sys_valid", wb_valid_o, 1);
        chk("sys_flags", wb_flags_o, 6'b000110);
        chk("sys_tag", wb_tag_o, 7'd1);
        wb_ready_i = 1;
        tick();
        wb_ready_i = 0;
        flush_i = 1;
        issue(OP_MULT_L, 32'd3, 32'd3, 7'd2);
        flush_i = 0;
        chk("flush_issue_idle", busy_o, 0);
        chk("flush_issue_op", alu_opcode_o, OP_SYSCALL);
        repeat (5) tick();
        issue(OP_DIV_L, 32'd77, 32'd3, 7'd4);
        repeat (2) tick();
        reset = 1;
        tick();
        tick();
        reset = 0;
        chk("rst2_busy", busy_o, 0);
        chk("rst2_valid", wb_valid_o, 0);
        chk("rst2_ready", issue_ready_o, 1);
        chk("rst2_result", wb_result_o, 0);
        chk("rst2_tag", wb_tag_o, 0);
        chk("rst2_data1", alu_data1_o, 0);
        chk("rst2_opcode", alu_opcode_o, 0);
        repeat (600) begin
            issue_valid_i = 1'($urandom_range(0, 1));
            wb_ready_i = ($urandom % 4) != 0;
            flush_i = ($urandom % 30) == 0;
            issue_opcode_i = ops[$urandom_range(0, 9)];
            issue_data1_i = $urandom;
            issue_data2_i = ($urandom % 8) == 0 ? 32'd0 : $urandom;
            issue_immd_i = 16'($urandom);
            issue_tag_i = 7'($urandom);
            tick();
        end
        issue_valid_i = 0;
        flush_i = 0;
        wb_ready_i = 1;
        repeat (20) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
